// File: rtl/fpc_pkg.sv
// Shared definitions for the filter PIO controller: command layout, opcodes,
// FSM encoding and status-word bit positions.
package fpc_pkg;

    typedef enum logic [2:0] {
        OpNop        = 3'd0,
        OpLoadCoef   = 3'd1,
        OpPushSample = 3'd2,
        OpReadHi     = 3'd3,
        OpReadLo     = 3'd4,
        OpClear      = 3'd5,
        OpRsvd6      = 3'd6,
        OpRsvd7      = 3'd7
    } opcode_e;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StExec = 2'd1,
        StAck  = 2'd2
    } state_e;

    // Mirrors the HPS command word bit for bit.
    typedef struct packed {
        logic        req;
        opcode_e     op;
        logic [3:0]  rsvd;
        logic [7:0]  idx;
        logic [15:0] data;
    } cmd_t;

    localparam int unsigned OutpAckBit      = 15;
    localparam int unsigned OutpErrBit      = 14;
    localparam int unsigned OutpBusyBit     = 13;
    localparam int unsigned OutpNonEmptyBit = 12;
    localparam int unsigned OutpOvfBit      = 11;
    localparam int unsigned OutpLevelLsb    = 8;
    localparam int unsigned OutpLevelW      = 3;

endpackage

// File: rtl/fpc_result_fifo.sv
// Result FIFO for filter outputs: wrap-around pointers, explicit level counter,
// sticky overflow; flush has priority over push and pop.
module fpc_result_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 16,
    localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned LW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic             overflow,
    output logic [LW-1:0]    level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [LW-1:0]    level_q;
    logic             ovf_q;
    logic             do_push, do_pop;

    assign empty    = (level_q == '0);
    assign full     = (level_q == LW'(DEPTH));
    assign do_pop   = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    assign do_push  = push && (!full || do_pop);
    assign head     = mem[rd_q];
    assign overflow = ovf_q;
    assign level    = level_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
        end else if (flush) begin
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop)  rd_q <= rd_q + AW'(1);
            level_q <= level_q + LW'(do_push) - LW'(do_pop);
            if (push && !do_push) ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_q] <= push_data;
    end

endmodule

// File: rtl/filter_pio_controller.sv
// Bridges a toggle-handshake HPS PIO command word to a streaming filter:
// coefficient writes, sample pushes with timeout, and result readback.
module filter_pio_controller
    import fpc_pkg::*;
#(
    parameter int unsigned COEF_AW    = 4,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned TIMEOUT    = 1024
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [31:0]        inp,
    output logic [15:0]        outp,
    output logic               flt_in_valid,
    input  logic               flt_in_ready,
    output logic [15:0]        flt_in_data,
    output logic               flt_coef_we,
    output logic [COEF_AW-1:0] flt_coef_addr,
    output logic [15:0]        flt_coef_data,
    input  logic               flt_out_valid,
    input  logic [15:0]        flt_out_data,
    output logic               flt_clear
);

    localparam int unsigned TW = $clog2(TIMEOUT + 1);
    localparam int unsigned LW = $clog2(FIFO_DEPTH + 1);

    state_e        state_q, state_d;
    cmd_t          sync1_q, sync2_q, cmd_q;
    logic          tog_q, ack_q, err_q, pend_err_q;
    logic [7:0]    byte_q, pend_byte_q;
    logic [TW-1:0] wait_q;

    logic          is_exec, idx_ok, timed_out, fifo_pop;
    logic          res_err;
    logic [7:0]    res_byte;
    logic [15:0]   fifo_head;
    logic          fifo_full, fifo_empty, fifo_ovf;
    logic [LW-1:0] fifo_level;
    logic          unused_cmd;

    assign unused_cmd = ^{cmd_q.req, cmd_q.rsvd, fifo_full};

    assign is_exec   = (state_q == StExec);
    assign idx_ok    = ((cmd_q.idx >> COEF_AW) == '0);
    assign timed_out = (wait_q == TW'(TIMEOUT - 1)) && !flt_in_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= StIdle;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: if (sync2_q.req != tog_q) state_d = StExec;
            StExec: begin
                if (cmd_q.op != OpPushSample || flt_in_ready || timed_out) state_d = StAck;
            end
            StAck:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        flt_in_valid  = is_exec && (cmd_q.op == OpPushSample);
        flt_in_data   = flt_in_valid ? cmd_q.data : '0;
        flt_coef_we   = is_exec && (cmd_q.op == OpLoadCoef) && idx_ok;
        flt_coef_addr = flt_coef_we ? cmd_q.idx[COEF_AW-1:0] : '0;
        flt_coef_data = flt_coef_we ? cmd_q.data : '0;
        flt_clear     = is_exec && (cmd_q.op == OpClear);
        fifo_pop      = is_exec && (cmd_q.op == OpReadLo);
    end

    // Result of the command in EXEC; captured on the cycle EXEC hands off to ACK.
    always_comb begin
        res_err  = 1'b0;
        res_byte = '0;
        case (cmd_q.op)
            OpLoadCoef:   res_err = !idx_ok;
            OpPushSample: res_err = !flt_in_ready;
            OpReadHi: begin
                res_err  = fifo_empty;
                res_byte = fifo_empty ? '0 : fifo_head[15:8];
            end
            OpReadLo: begin
                res_err  = fifo_empty;
                res_byte = fifo_empty ? '0 : fifo_head[7:0];
            end
            OpRsvd6, OpRsvd7: res_err = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            cmd_q       <= '0;
            tog_q       <= 1'b0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            byte_q      <= '0;
            pend_err_q  <= 1'b0;
            pend_byte_q <= '0;
            wait_q      <= '0;
        end else begin
            sync1_q <= cmd_t'(inp);
            sync2_q <= sync1_q;
            if (state_q == StIdle && state_d == StExec) begin
                cmd_q <= sync2_q;
                tog_q <= sync2_q.req;
            end
            if (flt_in_valid) wait_q <= wait_q + TW'(1);
            else              wait_q <= '0;
            if (is_exec && state_d == StAck) begin
                pend_err_q  <= res_err;
                pend_byte_q <= res_byte;
            end
            if (state_q == StAck) begin
                ack_q  <= tog_q;
                err_q  <= pend_err_q;
                byte_q <= pend_byte_q;
            end
        end
    end

    fpc_result_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (16)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (flt_out_valid),
        .push_data (flt_out_data),
        .pop       (fifo_pop),
        .flush     (flt_clear),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .overflow  (fifo_ovf),
        .level     (fifo_level)
    );

    always_comb begin
        outp                                    = '0;
        outp[OutpAckBit]                        = ack_q;
        outp[OutpErrBit]                        = err_q;
        outp[OutpBusyBit]                       = (state_q != StIdle);
        outp[OutpNonEmptyBit]                   = !fifo_empty;
        outp[OutpOvfBit]                        = fifo_ovf;
        outp[OutpLevelLsb +: OutpLevelW]        = OutpLevelW'(fifo_level);
        outp[7:0]                               = byte_q;
    end

endmodule
